// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// uart_pkg: shared state encoding and bus constants for the UART TX path.
// Revision 1.0
// ----------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } tx_state_t;

  localparam logic [7:0] UART_IDLE_BYTE  = 8'h00;
  localparam logic [1:0] UART_VALID_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// sync_fifo: single-clock first-word-fall-through FIFO with flush.
// Revision 1.0
// ----------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push coinciding with flush is discarded; no push while full.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------
// uart_tx_scheduler: queues command bytes and holds each on the UART bus until acked.
// Revision 1.0
// ----------------------------------------------------------------------
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_bits,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [7:0]                 uart_bits,
  input  logic                       uart_ready,
  output logic                       sent,
  output logic                       drop_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;

  tx_state_t   state;
  logic [GW-1:0] gap_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        accept;
  logic        byte_ok;
  logic        can_pop;

  assign accept    = in_valid & in_ready;
  assign byte_ok   = |(in_bits[1:0] & UART_VALID_MASK);
  assign fifo_push = accept & byte_ok;
  assign can_pop   = ~fifo_empty & ~flush;
  assign in_ready  = ~fifo_full;
  assign busy      = (state != ST_IDLE) || (count != '0);

  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE:    fifo_pop = can_pop;
      ST_PRESENT: fifo_pop = uart_ready && (GAP_CYCLES == 0) && can_pop;
      ST_GAP:     fifo_pop = (gap_cnt == '0) && can_pop;
      default:    fifo_pop = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (flush),
    .din     (in_bits),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // uart_bits doubles as the hold register: it carries the byte only in PRESENT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      uart_bits <= UART_IDLE_BYTE;
      gap_cnt   <= '0;
      sent      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      sent     <= 1'b0;
      drop_err <= accept & ~byte_ok;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            uart_bits <= fifo_dout;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (uart_ready) begin
            sent <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state     <= ST_GAP;
              gap_cnt   <= GW'(GAP_CYCLES - 1);
              uart_bits <= UART_IDLE_BYTE;
            end else if (fifo_pop) begin
              uart_bits <= fifo_dout;
            end else begin
              state     <= ST_IDLE;
              uart_bits <= UART_IDLE_BYTE;
            end
          end else if (flush) begin
            state     <= ST_IDLE;
            uart_bits <= UART_IDLE_BYTE;
          end
        end
        ST_GAP: begin
          // The last gap cycle hands straight to the next byte so the bus shows exactly GAP_CYCLES zeros.
          if (gap_cnt == '0) begin
            if (fifo_pop) begin
              uart_bits <= fifo_dout;
              state     <= ST_PRESENT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          uart_bits <= UART_IDLE_BYTE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
